// File: rtl/tstate_sequencer_pkg.sv
// rtl/tstate_sequencer_pkg.sv - shared T-state control encodings and constants
package tstate_sequencer_pkg;

    localparam int STEP_W        = 3;
    // Also used by the microcode ROM address generator
    localparam int DEFAULT_STEPS = 6;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/tstate_sequencer_if.sv
// rtl/tstate_sequencer_if.sv - control/status bundle between microcode and T-state sequencer
interface tstate_sequencer_if
    import tstate_sequencer_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic              run_mode;
    logic              step_req;
    logic              step_end;
    logic              hlt;
    logic [STEP_W-1:0] step;
    logic              dec_en;
    logic              tick;
    logic              instr_start;
    logic              halted;
    logic [CNT_W-1:0]  instr_cnt;

    modport master (
        output run_mode, step_req, step_end, hlt,
        input  step, dec_en, tick, instr_start, halted, instr_cnt
    );

    modport slave (
        input  run_mode, step_req, step_end, hlt,
        output step, dec_en, tick, instr_start, halted, instr_cnt
    );
endinterface

// File: rtl/tstate_sequencer_edge_detect.sv
// rtl/tstate_sequencer_edge_detect.sv - 1-bit rising-edge detector for synchronised button levels
module tstate_sequencer_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic d_q;

    // Previous-cycle copy of the level; runs regardless of sequencer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/tstate_sequencer.sv
// rtl/tstate_sequencer.sv - T-state generator feeding the 3-bit step decoder
module tstate_sequencer
    import tstate_sequencer_pkg::*;
#(
    parameter int STEPS = DEFAULT_STEPS,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    tstate_sequencer_if.slave   bus
);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    seq_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q;
    logic              start_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_rise;
    logic              adv;
    logic              wrap;

    tstate_sequencer_edge_detect u_step_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.step_req),
        .rise (req_rise)
    );

    // FSM state register; HALT is only left through reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and advance decision; hlt outranks any advance in the same cycle
    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        if (state_q == ST_RUN) begin
            if (bus.hlt) begin
                state_d = ST_HALT;
            end else begin
                adv = bus.run_mode | req_rise;
            end
        end
        wrap = adv & (bus.step_end | (step_q == LAST_STEP));
    end

    // Step counter, instruction-start flag and completed-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q  <= '0;
            start_q <= 1'b0;
            cnt_q   <= '0;
        end else if (state_q == ST_RUN && bus.hlt) begin
            start_q <= 1'b0;
        end else if (adv) begin
            if (wrap) begin
                step_q  <= '0;
                start_q <= 1'b1;
                cnt_q   <= cnt_q + CNT_W'(1);
            end else begin
                step_q  <= step_q + STEP_W'(1);
                start_q <= 1'b0;
            end
        end
    end

    assign bus.step        = step_q;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.dec_en      = (state_q == ST_RUN);
    assign bus.tick        = adv;
    assign bus.instr_start = start_q;
    assign bus.instr_cnt   = cnt_q;
endmodule

// File: tb/tb_tstate_sequencer.sv
// tb/tb_tstate_sequencer.sv - self-checking bench for tstate_sequencer
module tb_tstate_sequencer;
    localparam int STEPS = 6;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    tstate_sequencer_if #(.CNT_W(CNT_W)) bus ();

    tstate_sequencer #(.STEPS(STEPS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: instruction-level view of the sequencer
    int m_step      = 0;
    int m_cnt       = 0;
    bit m_halt      = 0;
    bit m_start     = 0;
    bit m_prev_req  = 0;

    function automatic bit m_adv();
        bit rise;
        rise = bus.step_req && !m_prev_req;
        return !m_halt && !bus.hlt && (bus.run_mode || rise);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_step = 0; m_cnt = 0; m_halt = 0; m_start = 0; m_prev_req = 0;
        end else begin
            if (!m_halt) begin
                if (bus.hlt) begin
                    m_halt  = 1;
                    m_start = 0;
                end else if (m_adv()) begin
                    if (bus.step_end || m_step == STEPS - 1) begin
                        m_step  = 0;
                        m_start = 1;
                        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
                    end else begin
                        m_step  = m_step + 1;
                        m_start = 0;
                    end
                end
            end
            m_prev_req = bus.step_req;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("step",        int'(bus.step),        m_step);
            chk("dec_en",      int'(bus.dec_en),      int'(!m_halt));
            chk("halted",      int'(bus.halted),      int'(m_halt));
            chk("instr_start", int'(bus.instr_start), int'(m_start));
            chk("instr_cnt",   int'(bus.instr_cnt),   m_cnt);
            chk("tick",        int'(bus.tick),        int'(m_adv()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_step"},   int'(bus.step),        0);
        chk({tag, "_dec_en"}, int'(bus.dec_en),      1);
        chk({tag, "_start"},  int'(bus.instr_start), 0);
        chk({tag, "_halted"}, int'(bus.halted),      0);
        chk({tag, "_cnt"},    int'(bus.instr_cnt),   0);
    endtask

    int ticks;

    initial begin
        bus.run_mode = 1'b0;
        bus.step_req = 1'b0;
        bus.step_end = 1'b0;
        bus.hlt      = 1'b0;
        #12;
        chk_reset_vals("rst0");

        // Free run, natural wrap at STEPS-1
        @(posedge clk);
        #2;
        rst          = 1'b0;
        bus.run_mode = 1'b1;
        cyc(12);
        chk("fr12_step",  int'(bus.step),        0);
        chk("fr12_cnt",   int'(bus.instr_cnt),   2);
        chk("fr12_start", int'(bus.instr_start), 1);
        cyc(2);
        chk("fr14_step", int'(bus.step), 2);

        // Early termination at step 2
        for (int i = 0; i < 9; i++) begin
            bus.step_end = (bus.step == 3'd2);
            cyc(1);
        end
        chk("se_step", int'(bus.step),      2);
        chk("se_cnt",  int'(bus.instr_cnt), 5);
        bus.step_end = 1'b1;
        cyc(1);
        chk("se_wrap_step", int'(bus.step), 0);

        // Single-step: three press/release pulses
        bus.step_end = 1'b0;
        bus.run_mode = 1'b0;
        ticks = 0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 10; c++) begin
                bus.step_req = (c < 5);
                #1;
                ticks += int'(bus.tick);
                @(posedge clk);
                #2;
            end
        end
        chk("ss_ticks", ticks,               3);
        chk("ss_step",  int'(bus.step),      3);
        chk("ss_cnt",   int'(bus.instr_cnt), 6);

        // Advance to step 4, then halt together with step_end
        bus.run_mode = 1'b1;
        cyc(1);
        bus.hlt      = 1'b1;
        bus.step_end = 1'b1;
        #1;
        chk("hlt_tick", int'(bus.tick), 0);
        cyc(1);
        chk("hlt_halted", int'(bus.halted),    1);
        chk("hlt_dec_en", int'(bus.dec_en),    0);
        chk("hlt_step",   int'(bus.step),      4);
        chk("hlt_cnt",    int'(bus.instr_cnt), 6);
        for (int i = 0; i < 6; i++) begin
            bus.run_mode = i[0];
            bus.step_req = i[1];
            bus.hlt      = i[2];
            bus.step_end = ~i[0];
            cyc(1);
        end
        chk("frz_step",   int'(bus.step),   4);
        chk("frz_halted", int'(bus.halted), 1);

        // Asynchronous reset while halted, between edges
        #1;
        rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        @(posedge clk);
        #2;
        bus.hlt      = 1'b0;
        bus.step_end = 1'b0;
        bus.step_req = 1'b0;
        bus.run_mode = 1'b1;
        rst          = 1'b0;
        cyc(1);
        chk("restart_step", int'(bus.step), 1);

        // 256 full instructions: counter wraps 255 -> 0
        cyc(STEPS * 255 - 1);
        chk("w255_cnt",   int'(bus.instr_cnt),   255);
        chk("w255_step",  int'(bus.step),        0);
        chk("w255_start", int'(bus.instr_start), 1);
        cyc(STEPS);
        chk("w256_cnt",   int'(bus.instr_cnt),   0);
        chk("w256_step",  int'(bus.step),        0);
        chk("w256_start", int'(bus.instr_start), 1);
        cyc(1);
        chk("w256_start_clr", int'(bus.instr_start), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
